quote_scheduler: RTL

Sequences two-sided quotes from `trading_logic` into `reverse_parser`, one at a time, across `NUM_STOCKS` instruments. Holds one pending quote slot per stock; a newer quote for the same stock replaces an unsent one. Grants stocks round-robin, defers grants while the order book is busy, and enforces a programmable minimum gap between emitted orders. Sits between `trading_logic`/`order_quantity` and `reverse_parser` in `hft_top`.

---
 rtl/hft_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/quote_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hft_pkg.sv
// Shared types for the HFT pipeline: scheduler FSM states and the default-width quote record.
package hft_pkg;

    localparam int unsigned NUM_STOCKS_DEF = 4;
    localparam int unsigned STOCK_ID_W     = $clog2(NUM_STOCKS_DEF);
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned QTY_W          = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

    // Quote as seen between trading_logic, the scheduler and reverse_parser at default widths.
    typedef struct packed {
        logic [STOCK_ID_W-1:0] stock_id;
        logic [DATA_W-1:0]     buy;
        logic [DATA_W-1:0]     sell;
        logic [QTY_W-1:0]      qty;
    } quote_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant, wrapping around.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_grant_i,
    output logic [N-1:0]         gnt_oh_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 any_req_o
);

    localparam int unsigned IdxW = $clog2(N);

    logic [IdxW-1:0] cand;
    logic            found;

    // Scan last_grant+1 .. last_grant+N; index arithmetic wraps because N is a power of two.
    always_comb begin
        gnt_idx_o = last_grant_i;
        found     = 1'b0;
        cand      = last_grant_i;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = last_grant_i + IdxW'(i);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = cand;
            end
        end
        gnt_oh_o  = found ? (N'(1) << gnt_idx_o) : '0;
        any_req_o = |req_i;
    end

endmodule

// File: rtl/quote_scheduler.sv
// Per-stock quote slots feeding reverse_parser one order at a time, round-robin, with an
// enforced idle gap after every accepted order.
module quote_scheduler
    import hft_pkg::*;
#(
    parameter int unsigned NUM_STOCKS = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned QTY_WIDTH  = 33,
    parameter int unsigned GAP_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_data_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic [DATA_WIDTH-1:0]         i_buy_price,
    input  logic [DATA_WIDTH-1:0]         i_sell_price,
    input  logic [QTY_WIDTH-1:0]          i_quantity,
    input  logic                          i_book_is_busy,
    input  logic [GAP_WIDTH-1:0]          i_min_gap,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic [DATA_WIDTH-1:0]         o_buy_price,
    output logic [DATA_WIDTH-1:0]         o_sell_price,
    output logic [QTY_WIDTH-1:0]          o_quantity,
    output logic [NUM_STOCKS-1:0]         o_pending,
    output logic [15:0]                   o_overwrite_cnt
);

    localparam int unsigned ID_W = $clog2(NUM_STOCKS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] buy;
        logic [DATA_WIDTH-1:0] sell;
        logic [QTY_WIDTH-1:0]  qty;
    } slot_t;

    slot_t                 slot_q [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] slot_vld_q, slot_vld_d;
    sched_state_e          state_q, state_d;
    logic [ID_W-1:0]       last_grant_q;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [ID_W-1:0]       out_id_q;
    slot_t                 out_q;
    logic [15:0]           ovw_cnt_q;

    logic [NUM_STOCKS-1:0] gnt_oh;
    logic [ID_W-1:0]       gnt_idx;
    logic                  any_req;
    logic                  grant;
    logic                  overwrite;

    rr_arbiter #(
        .N (NUM_STOCKS)
    ) u_arb (
        .req_i        (slot_vld_q),
        .last_grant_i (last_grant_q),
        .gnt_oh_o     (gnt_oh),
        .gnt_idx_o    (gnt_idx),
        .any_req_o    (any_req)
    );

    // FSM next state and gap counter.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        grant     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req && !i_book_is_busy) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (i_ready) begin
                    if (i_min_gap == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = i_min_gap;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot valid bits: grant clears, write sets afterwards so a same-cycle write survives.
    always_comb begin
        slot_vld_d = slot_vld_q;
        if (grant) begin
            slot_vld_d = slot_vld_d & ~gnt_oh;
        end
        if (i_data_valid) begin
            slot_vld_d = slot_vld_d | (NUM_STOCKS'(1) << i_stock_id);
        end
        overwrite = i_data_valid && slot_vld_q[i_stock_id] && !(grant && gnt_oh[i_stock_id]);
    end

    // Control, output register and overwrite counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            slot_vld_q   <= '0;
            last_grant_q <= ID_W'(NUM_STOCKS - 1);
            out_id_q     <= '0;
            out_q        <= '0;
            ovw_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            slot_vld_q <= slot_vld_d;
            if (grant) begin
                last_grant_q <= gnt_idx;
                out_id_q     <= gnt_idx;
                out_q        <= slot_q[gnt_idx];
            end
            if (overwrite && (ovw_cnt_q != 16'hFFFF)) begin
                ovw_cnt_q <= ovw_cnt_q + 16'd1;
            end
        end
    end

    // Slot payload storage; validity is tracked separately so this needs no reset.
    always_ff @(posedge i_clk) begin
        if (i_data_valid) begin
            slot_q[i_stock_id] <= '{buy: i_buy_price, sell: i_sell_price, qty: i_quantity};
        end
    end

    assign o_valid         = (state_q == ISSUE);
    assign o_stock_id      = out_id_q;
    assign o_buy_price     = out_q.buy;
    assign o_sell_price    = out_q.sell;
    assign o_quantity      = out_q.qty;
    assign o_pending       = slot_vld_q;
    assign o_overwrite_cnt = ovw_cnt_q;

endmodule
